// File: rtl/ascon_round_counter_if.sv
// Handshake bundle between the ASCON mode FSM (master) and the round sequencer (slave).
// abort_i exists only when ASCON_ROUND_ABORT_EN is defined.
interface ascon_round_counter_if;
   logic       start_i;
   logic       mode_i;
`ifdef ASCON_ROUND_ABORT_EN
   logic       abort_i;
`endif
   logic [3:0] round_o;
   logic       en_reg_state_o;
   logic       init_sel_o;
   logic       busy_o;
   logic       done_o;

`ifdef ASCON_ROUND_ABORT_EN
   modport master (
      output start_i, mode_i, abort_i,
      input  round_o, en_reg_state_o, init_sel_o, busy_o, done_o
   );

   modport slave (
      input  start_i, mode_i, abort_i,
      output round_o, en_reg_state_o, init_sel_o, busy_o, done_o
   );
`else
   modport master (
      output start_i, mode_i,
      input  round_o, en_reg_state_o, init_sel_o, busy_o, done_o
   );

   modport slave (
      input  start_i, mode_i,
      output round_o, en_reg_state_o, init_sel_o, busy_o, done_o
   );
`endif
endinterface

// File: rtl/ascon_round_counter.sv
// Round sequencer for the iterative ASCON permutation: round index plus state-register strobes.
// Optional synchronous cancel enabled by defining ASCON_ROUND_ABORT_EN.
module ascon_round_counter #(
   parameter int ROUNDS_A = 12,
   parameter int ROUNDS_B = 6
) (
   input logic                  clock_i,
   input logic                  reset_i,
   ascon_round_counter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] LAST_ROUND  = 4'd11;
   localparam logic [3:0] START_A     = 4'(12 - ROUNDS_A);
   localparam logic [3:0] START_B     = 4'(12 - ROUNDS_B);

   state_t     state_q, state_d;
   logic [3:0] round_q, round_d;
   logic       init_sel_q, init_sel_d;
   logic       en_q, en_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       abort_w;

`ifdef ASCON_ROUND_ABORT_EN
   assign abort_w = bus.abort_i;
`else
   assign abort_w = 1'b0;
`endif

   // The starting round index itself records the variant, so no separate mode flop is kept.
   always_comb begin
      state_d    = state_q;
      round_d    = round_q;
      init_sel_d = 1'b0;
      en_d       = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               state_d    = RUN;
               round_d    = bus.mode_i ? START_B : START_A;
               init_sel_d = 1'b1;
               en_d       = 1'b1;
               busy_d     = 1'b1;
            end else begin
               round_d = 4'd0;
            end
         end

         RUN: begin
            if (abort_w) begin
               state_d = IDLE;
               round_d = 4'd0;
            end else if (round_q < LAST_ROUND) begin
               round_d = round_q + 4'd1;
               en_d    = 1'b1;
               busy_d  = 1'b1;
            end else begin
               state_d = DONE;
               round_d = 4'd0;
               done_d  = 1'b1;
            end
         end

         DONE: begin
            if (abort_w) begin
               state_d = IDLE;
               round_d = 4'd0;
            end else if (bus.start_i) begin
               state_d    = RUN;
               round_d    = bus.mode_i ? START_B : START_A;
               init_sel_d = 1'b1;
               en_d       = 1'b1;
               busy_d     = 1'b1;
            end else begin
               state_d = IDLE;
               round_d = 4'd0;
            end
         end

         default: begin
            state_d = IDLE;
            round_d = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         round_q    <= 4'd0;
         init_sel_q <= 1'b0;
         en_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         round_q    <= round_d;
         init_sel_q <= init_sel_d;
         en_q       <= en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.round_o        = round_q;
   assign bus.en_reg_state_o = en_q;
   assign bus.init_sel_o     = init_sel_q;
   assign bus.busy_o         = busy_q;
   assign bus.done_o         = done_q;

endmodule

// File: tb/tb_ascon_round_counter.sv
// Scoreboard bench for ascon_round_counter: accepted starts queue their whole expected schedule,
// a negedge monitor pops one entry per cycle in which the DUT shows busy_o or done_o.
module tb_ascon_round_counter;

   logic clock_i = 1'b0;
   logic reset_i;

   ascon_round_counter_if bus ();

   ascon_round_counter #(
      .ROUNDS_A (12),
      .ROUNDS_B (6)
   ) dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .bus     (bus)
   );

   always #5 clock_i = ~clock_i;

`ifdef ASCON_ROUND_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] round;
      logic       init_sel;
      logic       done;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   left     = 0;
   bit   mon_en   = 1'b0;

   task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Expected schedule of one permutation: N rounds ending at index 11, then a done cycle.
   function automatic void plan(input logic mode);
      int n;
      n = mode ? 6 : 12;
      for (int i = 0; i < n; i++)
         exp_q.push_back('{round: 4'(12 - n + i), init_sel: (i == 0), done: 1'b0});
      exp_q.push_back('{round: 4'd0, init_sel: 1'b0, done: 1'b1});
      left = n + 1;
   endfunction

   // left: 0 = idle, 1 = done cycle, >1 = running
   task automatic apply_stimulus(input logic start, input logic mode, input logic abort);
      bus.start_i = start;
      bus.mode_i  = mode;
`ifdef ASCON_ROUND_ABORT_EN
      bus.abort_i = abort;
`endif
      @(posedge clock_i);
      if (ABORT_EN && abort && left >= 1) begin
         exp_q.delete();
         left = 0;
      end else if (start && left <= 1) begin
         plan(mode);
      end else if (left > 0) begin
         left--;
      end
      #1;
   endtask

   always @(negedge clock_i) begin
      exp_t e;
      if (mon_en && !reset_i) begin
         if (bus.busy_o || bus.done_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_output actual=busy%0b/done%0b required=idle at %0t",
                        bus.busy_o, bus.done_o, $time);
            end else begin
               e = exp_q.pop_front();
               check_output("round", {4'd0, bus.round_o}, {4'd0, e.round});
               check_output("init_sel", {7'd0, bus.init_sel_o}, {7'd0, e.init_sel});
               check_output("done", {7'd0, bus.done_o}, {7'd0, e.done});
               check_output("busy", {7'd0, bus.busy_o}, {7'd0, ~e.done});
               check_output("en_reg_state", {7'd0, bus.en_reg_state_o}, {7'd0, ~e.done});
            end
         end else begin
            check_output("idle_round", {4'd0, bus.round_o}, 8'd0);
            check_output("idle_strobes", {6'd0, bus.en_reg_state_o, bus.init_sel_o}, 8'd0);
            check_output("idle_pending", 8'(exp_q.size()), 8'd0);
         end
      end
   end

   initial begin
      reset_i     = 1'b1;
      bus.start_i = 1'b0;
      bus.mode_i  = 1'b0;
`ifdef ASCON_ROUND_ABORT_EN
      bus.abort_i = 1'b0;
`endif
      repeat (3) @(posedge clock_i);
      #1;
      check_output("reset_state",
                   {bus.round_o, bus.en_reg_state_o, bus.init_sel_o, bus.busy_o, bus.done_o}, 8'd0);
      @(negedge clock_i);
      #1;
      reset_i = 1'b0;
      mon_en  = 1'b1;

      $display("[TB] directed: p^a then p^b");
      apply_stimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) apply_stimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] directed: back-to-back with start held high");
      apply_stimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 19; i++) apply_stimulus(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] directed: start pulse and mode toggle mid-run");
      apply_stimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 1'b1, 1'b0);

      $display("[TB] directed: asynchronous reset during round 5");
      apply_stimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
      #1;
      reset_i = 1'b1;
      #1;
      check_output("async_reset",
                   {bus.round_o, bus.en_reg_state_o, bus.init_sel_o, bus.busy_o, bus.done_o}, 8'd0);
      exp_q.delete();
      left = 0;
      @(negedge clock_i);
      #1;
      reset_i = 1'b0;
      apply_stimulus(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 1500; i++)
         apply_stimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 15) == 0));
      for (int i = 0; i < 16; i++) apply_stimulus(1'b0, 1'b0, 1'b0);

      check_output("drained", 8'(exp_q.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
